// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART transmit arbiter.
//   arb_state_e      - arbiter FSM states
//   DefaultGapCycles - default idle gap inserted after every frame
//   idx_width()      - width of a requester index (at least 1 bit)
package uart_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StBusy,
      StGap
   } arb_state_e;

   localparam int unsigned DefaultGapCycles = 16;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker.
//   req_valid  - per-requester request bits
//   last_grant - index of the most recent owner
//   winner     - one-hot first set bit searching upward from last_grant+1, with wrap
//   winner_idx - binary index of winner (0 when nothing is requested)
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IdxW    = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IdxW-1:0]    last_grant,
   output logic [NUM_REQ-1:0] winner,
   output logic [IdxW-1:0]    winner_idx
);

   always_comb begin
      logic [IdxW-1:0] cand;
      logic            found;
      cand       = '0;
      found      = 1'b0;
      winner     = '0;
      winner_idx = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand = IdxW'((32'(last_grant) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found        = 1'b1;
            winner[cand] = 1'b1;
            winner_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte sources with
// round-robin arbitration, one byte in flight, and an idle gap after each frame.
//   PCLK, PRESETn           - clock, asynchronous active-low reset
//   arb_enable              - permits new grants (an in-flight frame always completes)
//   req_valid/req_data      - per-requester byte offer, slice i at [i*DATA_BITS +: DATA_BITS]
//   req_ready               - one-hot accept (combinational, IDLE only)
//   req_done                - one-cycle completion pulse to the owner
//   uart_tx_en/uart_tx_data - launch request and byte to uart_tx
//   uart_tx_busy/done       - status from uart_tx
//   grant_id, active        - current/last owner, non-idle indicator
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned DATA_BITS  = 8,
   parameter  int unsigned GAP_CYCLES = DefaultGapCycles,
   localparam int unsigned IdxW       = idx_width(NUM_REQ)
) (
   input  logic                         PCLK,
   input  logic                         PRESETn,
   input  logic                         arb_enable,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           req_done,
   output logic                         uart_tx_en,
   output logic [DATA_BITS-1:0]         uart_tx_data,
   input  logic                         uart_tx_busy,
   input  logic                         uart_tx_done,
   output logic [IdxW-1:0]              grant_id,
   output logic                         active
);

   localparam int unsigned GapW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int unsigned GapLoadInt = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [GapW-1:0] GapLoad = GapW'(GapLoadInt);

   arb_state_e           state_q, state_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic [IdxW-1:0]      grant_q, grant_d;
   logic [IdxW-1:0]      last_q, last_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 en_q, en_d;
   logic                 active_q;
   logic [GapW-1:0]      gap_q, gap_d;
   logic                 finish;

   logic [NUM_REQ-1:0]   pick_onehot;
   logic [IdxW-1:0]      pick_idx;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_valid  (req_valid),
      .last_grant (last_q),
      .winner     (pick_onehot),
      .winner_idx (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      grant_d   = grant_q;
      last_d    = last_q;
      en_d      = en_q;
      done_d    = '0;
      gap_d     = gap_q;
      finish    = 1'b0;
      req_ready = '0;
      unique case (state_q)
         StIdle: begin
            // Held low while in reset so no requester sees a spurious accept.
            if (PRESETn && arb_enable) req_ready = pick_onehot;
            if (|req_ready) begin
               for (int unsigned i = 0; i < NUM_REQ; i++) begin
                  if (pick_onehot[i]) data_d = req_data[i*DATA_BITS +: DATA_BITS];
               end
               grant_d = pick_idx;
               last_d  = pick_idx;
               en_d    = 1'b1;
               state_d = StLaunch;
            end
         end
         StLaunch: begin
            // A done seen before busy still ends the frame.
            if (uart_tx_done) begin
               finish = 1'b1;
            end else if (uart_tx_busy) begin
               en_d    = 1'b0;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (uart_tx_done) finish = 1'b1;
         end
         StGap: begin
            if (gap_q == '0) state_d = StIdle;
            else             gap_d   = gap_q - 1'b1;
         end
         default: state_d = StIdle;
      endcase

      if (finish) begin
         en_d            = 1'b0;
         done_d[grant_q] = 1'b1;
         if (GAP_CYCLES == 0) begin
            state_d = StIdle;
         end else begin
            state_d = StGap;
            gap_d   = GapLoad;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q  <= StIdle;
         data_q   <= '0;
         grant_q  <= '0;
         last_q   <= IdxW'(NUM_REQ - 1);
         done_q   <= '0;
         en_q     <= 1'b0;
         active_q <= 1'b0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         done_q   <= done_d;
         en_q     <= en_d;
         active_q <= (state_d != StIdle);
         gap_q    <= gap_d;
      end
   end

   assign req_done     = done_q;
   assign uart_tx_en   = en_q;
   assign uart_tx_data = data_q;
   assign grant_id     = grant_q;
   assign active       = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int NR  = 4;
   localparam int DB  = 8;
   localparam int GAP = 16;

   logic             PCLK = 1'b0;
   logic             PRESETn;
   logic             arb_enable;
   logic [NR-1:0]    req_valid;
   logic [NR*DB-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic [NR-1:0]    req_done;
   logic             uart_tx_en;
   logic [DB-1:0]    uart_tx_data;
   logic             uart_tx_busy;
   logic             uart_tx_done;
   logic [1:0]       grant_id;
   logic             active;

   // Second build with no inter-frame gap.
   logic [NR-1:0]    z_valid;
   logic [NR*DB-1:0] z_data;
   logic [NR-1:0]    z_ready;
   logic [NR-1:0]    z_done_out;
   logic             z_en;
   logic [DB-1:0]    z_txdata;
   logic             z_busy;
   logic             z_txdone;
   logic [1:0]       z_grant;
   logic             z_active;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int model_last;

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   uart_tx_arbiter #(
      .NUM_REQ    (NR),
      .DATA_BITS  (DB),
      .GAP_CYCLES (GAP)
   ) dut (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .arb_enable   (arb_enable),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .req_done     (req_done),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .uart_tx_busy (uart_tx_busy),
      .uart_tx_done (uart_tx_done),
      .grant_id     (grant_id),
      .active       (active)
   );

   uart_tx_arbiter #(
      .NUM_REQ    (NR),
      .DATA_BITS  (DB),
      .GAP_CYCLES (0)
   ) dut0 (
      .PCLK         (PCLK),
      .PRESETn      (PRESETn),
      .arb_enable   (arb_enable),
      .req_valid    (z_valid),
      .req_data     (z_data),
      .req_ready    (z_ready),
      .req_done     (z_done_out),
      .uart_tx_en   (z_en),
      .uart_tx_data (z_txdata),
      .uart_tx_busy (z_busy),
      .uart_tx_done (z_txdone),
      .grant_id     (z_grant),
      .active       (z_active)
   );

   // Reference arbitration rule: first requester above the last owner, wrapping.
   function automatic int rr_next(input int last, input logic [NR-1:0] v);
      for (int k = 1; k <= NR; k++) begin
         if (v[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   task automatic do_reset();
      @(negedge PCLK);
      PRESETn = 1'b0;
      @(negedge PCLK);
      PRESETn    = 1'b1;
      model_last = NR - 1;
   endtask

   task automatic wait_en(input int bound, output int at);
      int n = 0;
      while (uart_tx_en !== 1'b1 && n < bound) begin
         @(negedge PCLK);
         n++;
      end
      at = cyc;
      checks++;
      if (uart_tx_en !== 1'b1) begin
         failures++;
         $display("FAIL wait_en timeout: uart_tx_en=%b required 1", uart_tx_en);
      end
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while (active !== 1'b0 && n < bound) begin
         @(negedge PCLK);
         n++;
      end
      checks++;
      if (active !== 1'b0) begin
         failures++;
         $display("FAIL wait_idle timeout: active=%b required 0", active);
      end
   endtask

   // Plays uart_tx for one frame, starting at the first LAUNCH cycle.
   task automatic serve(input int id, input logic [DB-1:0] b, input int lat, input int flen,
                        input bit done_early, output int done_at);
      checks++;
      if (uart_tx_data !== b || grant_id !== 2'(id) || active !== 1'b1) begin
         failures++;
         $display("FAIL launch: data=%h grant=%0d active=%b required data=%h grant=%0d active=1",
                  uart_tx_data, grant_id, active, b, id);
      end
      checks++;
      if (req_ready !== '0) begin
         failures++;
         $display("FAIL ready_in_launch: req_ready=%b required 0000", req_ready);
      end
      repeat (lat) @(negedge PCLK);
      checks++;
      if (uart_tx_en !== 1'b1) begin
         failures++;
         $display("FAIL en_hold: uart_tx_en=%b required 1", uart_tx_en);
      end
      if (!done_early) begin
         uart_tx_busy = 1'b1;
         @(negedge PCLK);
         checks++;
         if (uart_tx_en !== 1'b0) begin
            failures++;
            $display("FAIL en_drop: uart_tx_en=%b required 0", uart_tx_en);
         end
         req_data = $urandom;
         repeat (flen) @(negedge PCLK);
         checks++;
         if (uart_tx_data !== b) begin
            failures++;
            $display("FAIL data_stable: uart_tx_data=%h required %h", uart_tx_data, b);
         end
         uart_tx_busy = 1'b0;
      end
      uart_tx_done = 1'b1;
      done_at      = cyc;
      @(negedge PCLK);
      uart_tx_done = 1'b0;
      checks++;
      if (req_done !== 4'(1 << id) || uart_tx_en !== 1'b0) begin
         failures++;
         $display("FAIL req_done: req_done=%b en=%b required %b en=0",
                  req_done, uart_tx_en, 4'(1 << id));
      end
      @(negedge PCLK);
      checks++;
      if (req_done !== '0) begin
         failures++;
         $display("FAIL done_pulse_width: req_done=%b required 0000", req_done);
      end
      model_last = id;
   endtask

   task automatic test_reset();
      PRESETn      = 1'b0;
      arb_enable   = 1'b1;
      req_valid    = 4'b1111;
      req_data     = $urandom;
      uart_tx_busy = 1'b0;
      uart_tx_done = 1'b0;
      z_valid      = '0;
      z_data       = '0;
      z_busy       = 1'b0;
      z_txdone     = 1'b0;
      repeat (2) @(negedge PCLK);
      checks++;
      if (req_ready !== '0) begin
         failures++;
         $display("FAIL reset_ready: req_ready=%b required 0000", req_ready);
      end
      checks++;
      if ({uart_tx_en, active, grant_id, req_done, uart_tx_data} !== 16'h0) begin
         failures++;
         $display("FAIL reset_outputs: en=%b active=%b grant=%0d done=%b data=%h required all 0",
                  uart_tx_en, active, grant_id, req_done, uart_tx_data);
      end
      req_valid = '0;
      @(negedge PCLK);
      PRESETn    = 1'b1;
      model_last = NR - 1;
      @(negedge PCLK);
      checks++;
      if (active !== 1'b0 || uart_tx_en !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: active=%b en=%b required 0 0", active, uart_tx_en);
      end
   endtask

   task automatic test_single();
      int d;
      req_data        = $urandom;
      req_data[23:16] = 8'hA5;
      req_valid       = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL single_ready: req_ready=%b required 0100", req_ready);
      end
      @(negedge PCLK);
      req_valid = '0;
      checks++;
      if (uart_tx_en !== 1'b1) begin
         failures++;
         $display("FAIL single_launch_latency: uart_tx_en=%b required 1", uart_tx_en);
      end
      serve(2, 8'hA5, 1, 4, 1'b0, d);
      wait_idle(GAP + 5);
   endtask

   task automatic test_round_robin();
      int en_at, prev_done, exp;
      do_reset();
      req_valid = 4'b1111;
      req_data  = $urandom;
      prev_done = 0;
      for (int g = 0; g < 5; g++) begin
         wait_en(GAP + 10, en_at);
         exp = rr_next(model_last, req_valid);
         checks++;
         if (grant_id !== 2'(exp)) begin
            failures++;
            $display("FAIL rr_order[%0d]: grant_id=%0d required %0d", g, grant_id, exp);
         end
         if (g > 0) begin
            checks++;
            if (en_at - prev_done != GAP + 2) begin
               failures++;
               $display("FAIL gap_spacing[%0d]: spacing=%0d required %0d",
                        g, en_at - prev_done, GAP + 2);
            end
         end
         serve(exp, req_data[exp*DB +: DB], $urandom_range(0, 3), $urandom_range(1, 6), 1'b0,
               prev_done);
      end
      req_valid = '0;
      wait_idle(GAP + 5);
   endtask

   task automatic test_wrap();
      int at, d, exp;
      do_reset();
      req_valid = 4'b1001;
      req_data  = $urandom;
      for (int g = 0; g < 2; g++) begin
         wait_en(GAP + 10, at);
         exp = rr_next(model_last, req_valid);
         checks++;
         if (grant_id !== 2'(exp)) begin
            failures++;
            $display("FAIL wrap[%0d]: grant_id=%0d required %0d", g, grant_id, exp);
         end
         serve(exp, req_data[exp*DB +: DB], 0, 2, 1'b0, d);
      end
      req_valid = '0;
      wait_idle(GAP + 5);
   endtask

   task automatic test_random();
      int at, d, exp;
      logic [NR-1:0] v;
      for (int t = 0; t < 10; t++) begin
         v         = 4'($urandom_range(1, 15));
         req_valid = v;
         req_data  = $urandom;
         wait_en(GAP + 10, at);
         exp = rr_next(model_last, v);
         checks++;
         if (grant_id !== 2'(exp)) begin
            failures++;
            $display("FAIL random_grant[%0d]: valid=%b grant_id=%0d required %0d",
                     t, v, grant_id, exp);
         end
         serve(exp, req_data[exp*DB +: DB], $urandom_range(0, 2), $urandom_range(1, 5),
               ($urandom_range(0, 3) == 0), d);
      end
      req_valid = '0;
      wait_idle(GAP + 5);
   endtask

   task automatic test_enable();
      int at, d, exp, exp2;
      bit bad;
      req_valid = 4'b0110;
      req_data  = $urandom;
      wait_en(GAP + 10, at);
      exp = rr_next(model_last, req_valid);
      uart_tx_busy = 1'b1;
      @(negedge PCLK);
      arb_enable = 1'b0;
      repeat (3) @(negedge PCLK);
      uart_tx_busy = 1'b0;
      uart_tx_done = 1'b1;
      @(negedge PCLK);
      uart_tx_done = 1'b0;
      checks++;
      if (req_done !== 4'(1 << exp)) begin
         failures++;
         $display("FAIL enable_done: req_done=%b required %b", req_done, 4'(1 << exp));
      end
      model_last = exp;
      bad = 1'b0;
      for (int i = 0; i < GAP + 20; i++) begin
         @(negedge PCLK);
         if (req_ready !== '0 || uart_tx_en !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad || active !== 1'b0) begin
         failures++;
         $display("FAIL enable_hold: grant while disabled=%b active=%b required 0 0", bad, active);
      end
      arb_enable = 1'b1;
      exp2       = rr_next(model_last, req_valid);
      #1;
      checks++;
      if (req_ready !== 4'(1 << exp2)) begin
         failures++;
         $display("FAIL enable_resume: req_ready=%b required %b", req_ready, 4'(1 << exp2));
      end
      @(negedge PCLK);
      serve(exp2, req_data[exp2*DB +: DB], 0, 3, 1'b0, d);
      req_valid = '0;
      wait_idle(GAP + 5);
   endtask

   task automatic test_reset_mid();
      int at, d;
      req_valid = 4'b0100;
      req_data  = $urandom;
      wait_en(GAP + 10, at);
      uart_tx_busy = 1'b1;
      @(negedge PCLK);
      req_valid = '0;
      PRESETn   = 1'b0;
      #1;
      checks++;
      if ({uart_tx_en, active, grant_id, req_done, uart_tx_data} !== 16'h0) begin
         failures++;
         $display("FAIL reset_mid: en=%b active=%b grant=%0d done=%b data=%h required all 0",
                  uart_tx_en, active, grant_id, req_done, uart_tx_data);
      end
      uart_tx_busy = 1'b0;
      @(negedge PCLK);
      PRESETn    = 1'b1;
      model_last = NR - 1;
      req_valid  = 4'b0011;
      req_data   = $urandom;
      #1;
      checks++;
      if (req_ready !== 4'(1 << rr_next(model_last, 4'b0011))) begin
         failures++;
         $display("FAIL reset_priority: req_ready=%b required %b",
                  req_ready, 4'(1 << rr_next(model_last, 4'b0011)));
      end
      @(negedge PCLK);
      req_valid = '0;
      serve(0, req_data[DB-1:0], 0, 2, 1'b0, d);
      wait_idle(GAP + 5);
   endtask

   task automatic test_gap0();
      int first, second;
      z_valid = 4'b0011;
      z_data  = $urandom;
      first   = rr_next(NR - 1, z_valid);
      second  = rr_next(first, z_valid);
      #1;
      checks++;
      if (z_ready !== 4'(1 << first)) begin
         failures++;
         $display("FAIL gap0_ready: req_ready=%b required %b", z_ready, 4'(1 << first));
      end
      @(negedge PCLK);
      checks++;
      if (z_en !== 1'b1 || z_grant !== 2'(first) || z_txdata !== z_data[first*DB +: DB]) begin
         failures++;
         $display("FAIL gap0_launch: en=%b grant=%0d data=%h required 1 %0d %h",
                  z_en, z_grant, z_txdata, first, z_data[first*DB +: DB]);
      end
      z_busy = 1'b1;
      @(negedge PCLK);
      z_busy   = 1'b0;
      z_txdone = 1'b1;
      @(negedge PCLK);
      z_txdone = 1'b0;
      checks++;
      if (z_done_out !== 4'(1 << first) || z_active !== 1'b0 || z_ready !== 4'(1 << second)) begin
         failures++;
         $display("FAIL gap0_idle: done=%b active=%b ready=%b required %b 0 %b",
                  z_done_out, z_active, z_ready, 4'(1 << first), 4'(1 << second));
      end
      @(negedge PCLK);
      z_valid = '0;
      checks++;
      if (z_en !== 1'b1 || z_grant !== 2'(second)) begin
         failures++;
         $display("FAIL gap0_second: en=%b grant=%0d required 1 %0d", z_en, z_grant, second);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_random();
      test_enable();
      test_reset_mid();
      test_gap0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
